// File: rtl/nes_clk_pkg.sv
// ============================================================================
// nes_clk_pkg : shared types and increment constants for NES clock enables
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

package nes_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int ACC_W_DEF = 24;

  // Frequencies are given in units of 0.01 Hz so the NTSC/PAL rates stay exact.
  function automatic logic [ACC_W_DEF-1:0] calc_inc(input logic [63:0] f_out_x100,
                                                    input logic [63:0] f_in_x100);
    logic [63:0] num;
    num = (f_out_x100 << ACC_W_DEF) + (f_in_x100 >> 1);
    return ACC_W_DEF'(num / f_in_x100);
  endfunction

  localparam logic [ACC_W_DEF-1:0] INC_NTSC_PPU_27M  = calc_inc(64'd536931818, 64'd2700000000);
  localparam logic [ACC_W_DEF-1:0] INC_NTSC_CPU_27M  = calc_inc(64'd178977273, 64'd2700000000);
  localparam logic [ACC_W_DEF-1:0] INC_PAL_PPU_27M   = calc_inc(64'd532034250, 64'd2700000000);
  localparam logic [ACC_W_DEF-1:0] INC_PAL_CPU_27M   = calc_inc(64'd166260703, 64'd2700000000);
  localparam logic [ACC_W_DEF-1:0] INC_NTSC_PPU_378M = calc_inc(64'd536931818, 64'd3780000000);
  localparam logic [ACC_W_DEF-1:0] INC_NTSC_CPU_378M = calc_inc(64'd178977273, 64'd3780000000);
  localparam logic [ACC_W_DEF-1:0] INC_PAL_PPU_378M  = calc_inc(64'd532034250, 64'd3780000000);
  localparam logic [ACC_W_DEF-1:0] INC_PAL_CPU_378M  = calc_inc(64'd166260703, 64'd3780000000);

endpackage

`default_nettype wire

// File: rtl/clken_accum.sv
// ============================================================================
// clken_accum : one phase-accumulator channel; carry out becomes the enable
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module clken_accum #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             run,
  input  logic [ACC_W-1:0] inc,
  output logic             ce
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum;

  // Leaving run discards the partial phase so every restart begins at zero.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, inc};
    acc_d = '0;
    ce_d  = 1'b0;
    if (run) begin
      acc_d = sum[ACC_W-1:0];
      ce_d  = sum[ACC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

`default_nettype wire

// File: rtl/pll_clken_gen.sv
// ============================================================================
// pll_clken_gen : lock-qualified multi-channel fractional clock-enable generator
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module pll_clken_gen
  import nes_clk_pkg::*;
#(
  parameter int                        CHANNELS    = 2,
  parameter int                        ACC_W       = ACC_W_DEF,
  parameter int                        LOCK_CYCLES = 1024,
  parameter logic [CHANNELS*ACC_W-1:0] INC_INIT    = {24'd1112128, 24'd3336383},
  localparam int                       SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                pll_lock,
  input  logic                inc_we,
  input  logic [SEL_W-1:0]    inc_sel,
  input  logic [ACC_W-1:0]    inc_data,
  output logic [CHANNELS-1:0] ce,
  output logic                ready,
  output logic [7:0]          lock_drops
);

  localparam int CNT_W = $clog2(LOCK_CYCLES);

  logic             sync1_q, sync2_q;
  logic             lk;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [7:0]       lock_drops_q, lock_drops_d;
  logic [ACC_W-1:0] inc_q [CHANNELS];
  logic [ACC_W-1:0] inc_d [CHANNELS];
  logic             lost;
  logic             run;

  assign lk = sync2_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lock_drops_d = lock_drops_q;
    lost         = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lk) state_d = SETTLE;
      end
      SETTLE: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          lost    = 1'b1;
        end else if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          lost    = 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
    if (lost && (lock_drops_q != 8'hFF)) lock_drops_d = lock_drops_q + 8'd1;
    ready_d = (state_d == RUN);
  end

  // Writes land in any state; a select beyond the channel count matches nothing.
  always_comb begin
    inc_d = inc_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (inc_we && (inc_sel == SEL_W'(i))) inc_d[i] = inc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      lock_drops_q <= '0;
      for (int i = 0; i < CHANNELS; i++) inc_q[i] <= INC_INIT[i*ACC_W +: ACC_W];
    end else begin
      sync1_q      <= pll_lock;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      lock_drops_q <= lock_drops_d;
      inc_q        <= inc_d;
    end
  end

  // Accumulate only while RUN is held; the cycle lock is seen lost already clears.
  assign run = (state_q == RUN) && lk;

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      clken_accum #(
        .ACC_W (ACC_W)
      ) u_accum (
        .clk    (clk),
        .resetn (resetn),
        .run    (run),
        .inc    (inc_q[g]),
        .ce     (ce[g])
      );
    end
  endgenerate

  assign ready      = ready_q;
  assign lock_drops = lock_drops_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_clken_gen.sv
// ============================================================================
// tb_pll_clken_gen : directed + random bench with a lock-streak reference model
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module tb_pll_clken_gen;

  localparam int          CH   = 2;
  localparam int          AW   = 8;
  localparam int          LC   = 16;
  localparam logic [15:0] INIT = {8'd64, 8'd128};

  logic       clk = 1'b0;
  logic       resetn;
  logic       pll_lock;
  logic       inc_we;
  logic [0:0] inc_sel;
  logic [7:0] inc_data;
  logic [1:0] ce;
  logic       ready;
  logic [7:0] lock_drops;

  pll_clken_gen #(
    .CHANNELS    (CH),
    .ACC_W       (AW),
    .LOCK_CYCLES (LC),
    .INC_INIT    (INIT)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pll_lock   (pll_lock),
    .inc_we     (inc_we),
    .inc_sel    (inc_sel),
    .inc_data   (inc_data),
    .ce         (ce),
    .ready      (ready),
    .lock_drops (lock_drops)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n0    = 0;
  int n1    = 0;

  // Reference model: the state is just the length of the current run of
  // synchronised-lock cycles; RUN means the run has exceeded LC cycles.
  bit m_h1, m_h2, m_ready;
  int m_streak, m_drops;
  int m_acc [CH];
  int m_inc [CH];
  bit m_ce  [CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    bit lk;
    bit was_run;
    int s;
    @(posedge clk);
    cyc++;
    if (!resetn) begin
      m_h1 = 0; m_h2 = 0; m_streak = 0; m_drops = 0; m_ready = 0;
      for (int i = 0; i < CH; i++) begin
        m_acc[i] = 0;
        m_ce[i]  = 0;
        m_inc[i] = int'(INIT[i*AW +: AW]);
      end
    end else begin
      lk      = m_h2;
      m_h2    = m_h1;
      m_h1    = pll_lock;
      was_run = (m_streak >= LC + 1);
      if (lk) begin
        if (m_streak < 1000000) m_streak++;
      end else begin
        if (m_streak > 0 && m_drops < 255) m_drops++;
        m_streak = 0;
      end
      for (int i = 0; i < CH; i++) begin
        if (was_run && lk) begin
          s        = m_acc[i] + m_inc[i];
          m_ce[i]  = (s >= 256);
          m_acc[i] = s % 256;
        end else begin
          m_acc[i] = 0;
          m_ce[i]  = 0;
        end
      end
      m_ready = (m_streak >= LC + 1);
      if (inc_we) m_inc[inc_sel] = int'(inc_data);
    end
    #1;
    chk("model_ce", 32'(ce), 32'({m_ce[1], m_ce[0]}));
    chk("model_ready", 32'(ready), 32'(m_ready));
    chk("model_drops", 32'(lock_drops), 32'(m_drops));
    n0 += int'(ce[0]);
    n1 += int'(ce[1]);
  endtask

  task automatic wait_ready(input string tag);
    for (int k = 0; k < 60 && ready !== 1'b1; k++) step();
    chk(tag, 32'(ready), 32'd1);
  endtask

  task automatic write_inc(input logic sel, input logic [7:0] data);
    inc_we   = 1'b1;
    inc_sel  = sel;
    inc_data = data;
    step();
    inc_we   = 1'b0;
  endtask

  initial begin
    resetn   = 1'b0;
    pll_lock = 1'b0;
    inc_we   = 1'b0;
    inc_sel  = 1'b0;
    inc_data = 8'd0;

    // Reset and lock gating: ready on the 19th edge after lock is applied.
    repeat (4) step();
    chk("reset_ce", 32'(ce), 32'd0);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_drops", 32'(lock_drops), 32'd0);
    resetn   = 1'b1;
    pll_lock = 1'b1;
    repeat (18) step();
    chk("t1_ready_not_before_19", 32'(ready), 32'd0);
    step();
    chk("t1_ready_at_19", 32'(ready), 32'd1);

    // First pulses from acc=0: ch0 two edges after RUN entry, ch1 four.
    step();
    chk("t2_ce_plus1", 32'(ce), 32'd0);
    step();
    chk("t2_ce_plus2", 32'(ce), 32'b01);
    step();
    chk("t2_ce_plus3", 32'(ce), 32'b00);
    step();
    chk("t2_ce_plus4", 32'(ce), 32'b11);
    n0 = 0; n1 = 0;
    repeat (32) step();
    chk("t2_ch0_rate", 32'(n0), 32'd16);
    chk("t2_ch1_rate", 32'(n1), 32'd8);

    // Mid-phase rate change keeps phase: exactly 85 pulses per 256 cycles.
    write_inc(1'b0, 8'd85);
    n0 = 0;
    repeat (256) step();
    chk("t5_ch0_85", 32'(n0), 32'd85);
    // inc_sel is one bit wide with two channels, so every select is in range.

    // Increment extremes.
    write_inc(1'b0, 8'd0);
    write_inc(1'b1, 8'd255);
    n0 = 0; n1 = 0;
    repeat (256) step();
    chk("inc_zero_never", 32'(n0), 32'd0);
    chk("inc_max_rate", 32'(n1), 32'd255);

    // Lock loss in RUN: outputs drop on the third edge; relock restarts from 0.
    write_inc(1'b0, 8'd128);
    write_inc(1'b1, 8'd64);
    pll_lock = 1'b0;
    step();
    step();
    chk("t4_ready_held", 32'(ready), 32'd1);
    step();
    chk("t4_ready_off", 32'(ready), 32'd0);
    chk("t4_ce_off", 32'(ce), 32'd0);
    chk("t4_drop_count", 32'(lock_drops), 32'd1);
    pll_lock = 1'b1;
    wait_ready("t4_relock");
    step();
    chk("t4_restart_plus1", 32'(ce), 32'b00);
    step();
    chk("t4_restart_plus2", 32'(ce), 32'b01);

    // Glitch seen at settle count 10 forces a full restart of the settle.
    resetn = 1'b0;
    step();
    resetn   = 1'b1;
    pll_lock = 1'b1;
    repeat (11) step();
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    step();
    step();
    chk("t3_glitch_drop", 32'(lock_drops), 32'd1);
    chk("t3_glitch_ready", 32'(ready), 32'd0);
    repeat (16) step();
    chk("t3_full_settle_pre", 32'(ready), 32'd0);
    step();
    chk("t3_full_settle", 32'(ready), 32'd1);

    // Random lock glitches and increment writes against the model.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(63) == 0) pll_lock = 1'b0;
      else if ($urandom_range(3) == 0) pll_lock = 1'b1;
      inc_we  = ($urandom_range(7) == 0);
      inc_sel = 1'($urandom_range(1));
      case ($urandom_range(5))
        0:       inc_data = 8'd0;
        1:       inc_data = 8'd255;
        default: inc_data = 8'($urandom_range(255));
      endcase
      step();
    end
    inc_we = 1'b0;

    // Saturation after 300 losses in SETTLE.
    for (int k = 0; k < 300; k++) begin
      pll_lock = 1'b1;
      repeat (3) step();
      pll_lock = 1'b0;
      repeat (3) step();
    end
    chk("t6_saturated", 32'(lock_drops), 32'd255);

    // Reset mid-RUN overrides a pending write and restores INC_INIT.
    pll_lock = 1'b1;
    wait_ready("t6_ready");
    write_inc(1'b0, 8'd85);
    repeat (5) step();
    resetn   = 1'b0;
    inc_we   = 1'b1;
    inc_sel  = 1'b1;
    inc_data = 8'd7;
    step();
    inc_we = 1'b0;
    chk("t6_reset_ce", 32'(ce), 32'd0);
    chk("t6_reset_ready", 32'(ready), 32'd0);
    chk("t6_reset_drops", 32'(lock_drops), 32'd0);
    resetn = 1'b1;
    wait_ready("t6_relock");
    step();
    chk("t6_init_plus1", 32'(ce), 32'b00);
    step();
    chk("t6_init_plus2", 32'(ce), 32'b01);
    step();
    chk("t6_init_plus3", 32'(ce), 32'b00);
    step();
    chk("t6_init_plus4", 32'(ce), 32'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
